// File: rtl/iter_div.sv
// Multi-cycle restoring divider: one quotient bit per clock, unsigned or signed per operation.
// Signed operands are divided as magnitudes and the signs are fixed up on the last step.
module iter_div #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             signed_mode,
    input  logic [WIDTH-1:0] operandA,
    input  logic [WIDTH-1:0] operandB,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_div,
    output logic [WIDTH-1:0] out_rem,
    output logic             div_by_zero
);

    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q;
    logic [WIDTH-1:0] dvd_q, dvs_q, rem_q, quo_q;
    logic            quo_neg_q, rem_neg_q;

    logic             a_neg, b_neg, last_step, q_bit;
    logic [WIDTH-1:0] a_mag, b_mag;
    logic [WIDTH:0]   rem_shift, trial;
    logic [WIDTH-1:0] rem_next, quo_next, quo_fix, rem_fix;

    always_comb begin
        a_neg = signed_mode & operandA[WIDTH-1];
        b_neg = signed_mode & operandB[WIDTH-1];
        // -x of the most negative value wraps to itself, which is its correct unsigned magnitude
        a_mag = a_neg ? -operandA : operandA;
        b_mag = b_neg ? -operandB : operandB;

        rem_shift = {rem_q, dvd_q[WIDTH-1]};
        trial     = rem_shift - {1'b0, dvs_q};
        q_bit     = ~trial[WIDTH];
        rem_next  = q_bit ? trial[WIDTH-1:0] : rem_shift[WIDTH-1:0];
        quo_next  = {quo_q[WIDTH-2:0], q_bit};
        quo_fix   = quo_neg_q ? -quo_next : quo_next;
        rem_fix   = rem_neg_q ? -rem_next : rem_next;

        last_step = (cnt_q == CW'(WIDTH - 1));
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    state_d = (operandB == '0) ? StDone : StCalc;
                end
            end
            StCalc: begin
                if (last_step) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign in_ready  = (state_q == StIdle);
    assign out_valid = (state_q == StDone);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q       <= '0;
            dvd_q       <= '0;
            dvs_q       <= '0;
            rem_q       <= '0;
            quo_q       <= '0;
            quo_neg_q   <= 1'b0;
            rem_neg_q   <= 1'b0;
            out_div     <= '0;
            out_rem     <= '0;
            div_by_zero <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (in_valid) begin
                        cnt_q     <= '0;
                        dvd_q     <= a_mag;
                        dvs_q     <= b_mag;
                        rem_q     <= '0;
                        quo_q     <= '0;
                        quo_neg_q <= a_neg ^ b_neg;
                        rem_neg_q <= a_neg;
                        if (operandB == '0) begin
                            out_div     <= '1;
                            out_rem     <= operandA;
                            div_by_zero <= 1'b1;
                        end
                    end
                end
                StCalc: begin
                    dvd_q <= dvd_q << 1;
                    rem_q <= rem_next;
                    quo_q <= quo_next;
                    if (last_step) begin
                        cnt_q       <= '0;
                        out_div     <= quo_fix;
                        out_rem     <= rem_fix;
                        div_by_zero <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_iter_div.sv
// Directed checks of iter_div at WIDTH=8 plus a randomised sweep at WIDTH=16
// against a truncate-toward-zero reference.
module tb_iter_div;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    logic       in_valid, in_ready, signed_mode, out_valid, out_ready, div_by_zero;
    logic [7:0] op_a, op_b, out_div, out_rem;

    logic        in_valid16, in_ready16, signed_mode16, out_valid16, out_ready16, dbz16;
    logic [15:0] op_a16, op_b16, out_div16, out_rem16;

    iter_div #(.WIDTH(8)) u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .signed_mode(signed_mode), .operandA(op_a), .operandB(op_b),
        .out_valid(out_valid), .out_ready(out_ready), .out_div(out_div),
        .out_rem(out_rem), .div_by_zero(div_by_zero)
    );

    iter_div #(.WIDTH(16)) u_dut16 (
        .clk(clk), .rst(rst), .in_valid(in_valid16), .in_ready(in_ready16),
        .signed_mode(signed_mode16), .operandA(op_a16), .operandB(op_b16),
        .out_valid(out_valid16), .out_ready(out_ready16), .out_div(out_div16),
        .out_rem(out_rem16), .div_by_zero(dbz16)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Called at #1 after a posedge while idle; returns at #1 after the edge that raised out_valid.
    task automatic run8(input logic s, input logic [7:0] a, input logic [7:0] b, input logic poke,
                        output logic [7:0] q, output logic [7:0] r, output logic dz,
                        output int n);
        in_valid    = 1'b1;
        signed_mode = s;
        op_a        = a;
        op_b        = b;
        @(posedge clk);
        #1;
        op_a = ~a;
        op_b = 8'h01;
        n    = 0;
        while (!out_valid && n < 40) begin
            in_valid = poke;
            @(posedge clk);
            #1;
            n++;
        end
        in_valid = 1'b0;
        q  = out_div;
        r  = out_rem;
        dz = div_by_zero;
    endtask

    // With out_ready high, out_valid must drop after one cycle and the divider be ready again.
    task automatic retire8(input string tag);
        @(posedge clk);
        #1;
        check({tag, " valid_drop"}, out_valid, 1'b0);
        check({tag, " ready_back"}, in_ready, 1'b1);
    endtask

    task automatic op8(input string tag, input logic s, input logic [7:0] a, input logic [7:0] b,
                       input logic [7:0] eq, input logic [7:0] er, input logic edz,
                       input int elat);
        logic [7:0] q, r;
        logic       dz;
        int         n;
        run8(s, a, b, 1'b0, q, r, dz, n);
        check({tag, " quo"}, q, eq);
        check({tag, " rem"}, r, er);
        check({tag, " dbz"}, dz, edz);
        check({tag, " lat"}, n, elat);
        retire8(tag);
    endtask

    task automatic run16(input logic s, input logic [15:0] a, input logic [15:0] b,
                         output logic [15:0] q, output logic [15:0] r, output logic dz,
                         output int n);
        in_valid16    = 1'b1;
        signed_mode16 = s;
        op_a16        = a;
        op_b16        = b;
        @(posedge clk);
        #1;
        in_valid16 = 1'b0;
        op_a16     = ~a;
        n          = 0;
        while (!out_valid16 && n < 60) begin
            @(posedge clk);
            #1;
            n++;
        end
        q  = out_div16;
        r  = out_rem16;
        dz = dbz16;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0]  q, r;
        logic        dz;
        int          n;
        logic [15:0] a16, b16, q16, r16, eq16, er16;
        logic        dz16, s16, edz16;
        logic signed [15:0] sa, sb;

        rst           = 1'b1;
        in_valid      = 1'b0;
        signed_mode   = 1'b0;
        op_a          = 8'h00;
        op_b          = 8'h00;
        out_ready     = 1'b1;
        in_valid16    = 1'b0;
        signed_mode16 = 1'b0;
        op_a16        = 16'h0;
        op_b16        = 16'h0;
        out_ready16   = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check("reset in_ready", in_ready, 1'b1);
        check("reset out_valid", out_valid, 1'b0);
        check("reset out_div", out_div, 8'h00);
        check("reset out_rem", out_rem, 8'h00);
        check("reset dbz", div_by_zero, 1'b0);
        @(posedge clk);
        #1;

        op8("u 16/3", 1'b0, 8'd16, 8'd3, 8'd5, 8'd1, 1'b0, 8);
        op8("s -7/2", 1'b1, 8'hF9, 8'h02, 8'hFD, 8'hFF, 1'b0, 8);
        op8("s 7/-2", 1'b1, 8'h07, 8'hFE, 8'hFD, 8'h01, 1'b0, 8);
        op8("s -7/-2", 1'b1, 8'hF9, 8'hFE, 8'h03, 8'hFF, 1'b0, 8);
        op8("s -8/2", 1'b1, 8'hF8, 8'h02, 8'hFC, 8'h00, 1'b0, 8);
        op8("u dz", 1'b0, 8'h10, 8'h00, 8'hFF, 8'h10, 1'b1, 0);
        op8("u 200/9", 1'b0, 8'd200, 8'd9, 8'd22, 8'd2, 1'b0, 8);
        op8("s dz", 1'b1, 8'h10, 8'h00, 8'hFF, 8'h10, 1'b1, 0);
        op8("s dz neg", 1'b1, 8'h90, 8'h00, 8'hFF, 8'h90, 1'b1, 0);
        op8("s ovf", 1'b1, 8'h80, 8'hFF, 8'h80, 8'h00, 1'b0, 8);
        op8("u ff/1", 1'b0, 8'hFF, 8'h01, 8'hFF, 8'h00, 1'b0, 8);
        op8("u 7/200", 1'b0, 8'd7, 8'd200, 8'd0, 8'd7, 1'b0, 8);

        // Backpressure, with stray in_valid pulses through CALC and DONE
        out_ready = 1'b0;
        run8(1'b0, 8'd200, 8'd9, 1'b1, q, r, dz, n);
        check("bp quo", q, 8'd22);
        check("bp rem", r, 8'd2);
        check("bp lat", n, 8);
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            op_a     = 8'd3;
            op_b     = 8'd1;
            @(posedge clk);
            #1;
            check($sformatf("bp hold valid %0d", i), out_valid, 1'b1);
            check($sformatf("bp hold quo %0d", i), out_div, 8'd22);
            check($sformatf("bp hold rem %0d", i), out_rem, 8'd2);
            check($sformatf("bp hold ready %0d", i), in_ready, 1'b0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("bp after valid", out_valid, 1'b0);
        check("bp after ready", in_ready, 1'b1);
        check("bp quo held", out_div, 8'd22);
        @(posedge clk);
        #1;
        check("bp no stray accept", in_ready, 1'b1);

        // Asynchronous reset with the step counter at 3
        in_valid    = 1'b1;
        signed_mode = 1'b0;
        op_a        = 8'd200;
        op_b        = 8'd9;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("rst mid in_ready", in_ready, 1'b1);
        check("rst mid out_valid", out_valid, 1'b0);
        check("rst mid out_div", out_div, 8'h00);
        check("rst mid out_rem", out_rem, 8'h00);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        op8("u 100/7", 1'b0, 8'd100, 8'd7, 8'd14, 8'd2, 1'b0, 8);

        // WIDTH=16 randomised sweep
        for (int i = 0; i < 400; i++) begin
            s16 = 1'(i % 2);
            a16 = 16'($urandom);
            b16 = 16'($urandom);
            if (i % 10 == 5) b16 = b16 >> 12;
            if (i % 20 == 3) b16 = 16'h0;
            if (i % 50 == 7) begin
                a16 = 16'h8000;
                b16 = 16'hFFFF;
            end
            sa    = a16;
            sb    = b16;
            edz16 = (b16 == 16'h0);
            if (b16 == 16'h0) begin
                eq16 = 16'hFFFF;
                er16 = a16;
            end else if (s16 && a16 == 16'h8000 && b16 == 16'hFFFF) begin
                eq16 = 16'h8000;
                er16 = 16'h0000;
            end else if (s16) begin
                eq16 = sa / sb;
                er16 = sa % sb;
            end else begin
                eq16 = a16 / b16;
                er16 = a16 % b16;
            end
            run16(s16, a16, b16, q16, r16, dz16, n);
            check($sformatf("w16 #%0d quo s=%0b %h/%h", i, s16, a16, b16), q16, eq16);
            check($sformatf("w16 #%0d rem s=%0b %h/%h", i, s16, a16, b16), r16, er16);
            check($sformatf("w16 #%0d dbz", i), dz16, edz16);
            check($sformatf("w16 #%0d lat", i), n, edz16 ? 0 : 16);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
